orion_mem_responder: RTL and testbench

- Responder (slave) end of the core's cache/memory request interface: addr, valid, rdata, wdata, mask, we, ack.
- Sits behind the IF or MEM stage port as a word-addressed backing RAM with programmable response latency.
- Used as the instruction or data memory model in simulation and small FPGA builds.
- Accepts one request at a time, commits byte-masked writes, returns read data with a single-cycle ack pulse.

---
 rtl/orion_mem_responder.sv | 118 +++++++++++
 tb/tb_orion_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/orion_mem_responder.sv
// Word-addressed backing RAM that answers the core's memory request interface.
// A request is captured in IDLE, waits LATENCY cycles, then completes with a one-cycle ack.
module orion_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDXW  = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] idx,
  input  logic [7:0]      wbyte,
  output logic [7:0]      rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module orion_mem_responder #(
  parameter int ADDRW   = 32,
  parameter int DATAW   = 32,
  parameter int MASKW   = DATAW / 8,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] addr_i,
  input  logic             valid_i,
  input  logic             we_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic [MASKW-1:0] mask_i,
  output logic [DATAW-1:0] rdata_o,
  output logic             ack_o
);
  localparam int OFFW = $clog2(MASKW);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef struct packed {
    logic [IDXW-1:0]  idx;
    logic             we;
    logic [DATAW-1:0] wdata;
    logic [MASKW-1:0] mask;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic capture, enter_resp;
  req_t req_q, req_in, req_cur;
  logic [MASKW-1:0][7:0] rword;

  // Byte offset and bits above the RAM index are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign req_in = '{idx: addr_i[OFFW +: IDXW], we: we_i, wdata: wdata_i, mask: mask_i};
  // With LATENCY=0 the RESP-entry edge is also the capture edge, so use live inputs.
  assign req_cur = (state == IDLE) ? req_in : req_q;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (valid_i) begin
        capture = 1'b1;
        cnt_d   = LAT4;
        if (LAT4 == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar b = 0; b < MASKW; b++) begin : g_lane
    orion_mem_lane #(.DEPTH(DEPTH), .IDXW(IDXW)) u_lane (
      .clk   (clk_i),
      .we    (enter_resp && req_cur.we && req_cur.mask[b]),
      .idx   (req_cur.idx),
      .wbyte (req_cur.wdata[8*b +: 8]),
      .rbyte (rword[b])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (capture) req_q <= req_in;
      ack_o   <= enter_resp;
      rdata_o <= (enter_resp && !req_cur.we) ? DATAW'(rword) : '0;
    end
  end
endmodule

// File: tb/tb_orion_mem_responder.sv
// Directed bench for orion_mem_responder: four instances at LATENCY 0,1,3,5
// share one clock; each has its own request and reset signals.
module tb_orion_mem_responder;
  logic        clk = 1'b0;
  logic        rst   [4];
  logic        valid [4];
  logic        we    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  mask  [4];
  logic [31:0] rdata [4];
  logic        ack   [4];

  int checks = 0;
  int errors = 0;
  int lat_of [4] = '{0, 1, 3, 5};
  logic [31:0] mdl [16];

  always #5 clk = ~clk;

  orion_mem_responder #(.LATENCY(0)) u_l0 (.clk_i(clk), .rst_i(rst[0]), .addr_i(addr[0]),
    .valid_i(valid[0]), .we_i(we[0]), .wdata_i(wdata[0]), .mask_i(mask[0]), .rdata_o(rdata[0]), .ack_o(ack[0]));
  orion_mem_responder #(.LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst[1]), .addr_i(addr[1]),
    .valid_i(valid[1]), .we_i(we[1]), .wdata_i(wdata[1]), .mask_i(mask[1]), .rdata_o(rdata[1]), .ack_o(ack[1]));
  orion_mem_responder #(.LATENCY(3)) u_l3 (.clk_i(clk), .rst_i(rst[2]), .addr_i(addr[2]),
    .valid_i(valid[2]), .we_i(we[2]), .wdata_i(wdata[2]), .mask_i(mask[2]), .rdata_o(rdata[2]), .ack_o(ack[2]));
  orion_mem_responder #(.LATENCY(5)) u_l5 (.clk_i(clk), .rst_i(rst[3]), .addr_i(addr[3]),
    .valid_i(valid[3]), .we_i(we[3]), .wdata_i(wdata[3]), .mask_i(mask[3]), .rdata_o(rdata[3]), .ack_o(ack[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge and waits for its ack; the ack must land exp_lat negedges later.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input int exp_lat, input logic [31:0] exp_rd, input string tag);
    int k;
    bit got;
    valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; mask[d] = m;
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (ack[d] === 1'b1) got = 1;
    end
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " rdata"}, rdata[d], exp_rd);
  endtask

  // Drops valid and checks the ack pulse ended with rdata back at zero.
  task automatic rel(input int d, input string tag);
    valid[d] = 1'b0;
    @(negedge clk);
    chk({tag, " ack drop"}, {31'd0, ack[d]}, 32'd0);
    chk({tag, " rdata drop"}, rdata[d], 32'd0);
  endtask

  initial begin
    logic [10:0] ackv;
    logic [31:0] rd4;
    bit seen;
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; mask[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("reset ack", {31'd0, ack[d]}, 32'd0);
      chk("reset rdata", rdata[d], 32'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // Basic write/read, masked write, alignment and wrap at LATENCY=0.
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, "t1 write"); rel(0, "t1w");
    txn(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, "t1 read"); rel(0, "t1r");
    txn(0, 1, 32'h10, 32'h11223344, 4'b0101, 1, 32'h0, "t2 write"); rel(0, "t2w");
    txn(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDE22BE44, "t2 read"); rel(0, "t2r");
    txn(0, 1, 32'h13, 32'hA5A5A5A5, 4'hF, 1, 32'h0, "t4 unaligned write"); rel(0, "t4a");
    txn(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hA5A5A5A5, "t4 aligned read"); rel(0, "t4b");
    txn(0, 1, 32'h1000, 32'h5A5A5A5A, 4'hF, 1, 32'h0, "t4 wrap write"); rel(0, "t4c");
    txn(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h5A5A5A5A, "t4 wrap read"); rel(0, "t4d");
    txn(0, 1, 32'h8, 32'h01020304, 4'h0, 1, 32'h0, "mask0 write"); rel(0, "m0w");

    // Held read at LATENCY=3: acks in cycles 4 and 9 only.
    txn(2, 1, 32'h40, 32'h87654321, 4'hF, 4, 32'h0, "t3 prewrite"); rel(2, "t3p");
    valid[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
    ackv = '0; rd4 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ackv[k] = ack[2];
      if (k == 4) rd4 = rdata[2];
      if (k == 10) valid[2] = 1'b0;
    end
    chk("t3 ack pattern", {21'd0, ackv}, 32'h210);
    chk("t3 rdata", rd4, 32'h87654321);
    @(negedge clk);

    // Reset during WAIT drops the uncommitted write.
    txn(2, 1, 32'h20, 32'h0, 4'hF, 4, 32'h0, "t5 prewrite"); rel(2, "t5p");
    valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D; mask[2] = 4'hF;
    seen = 0;
    @(negedge clk); seen |= ack[2];
    @(negedge clk); seen |= ack[2];
    rst[2] = 1'b1; valid[2] = 1'b0;
    #1 seen |= ack[2];
    @(negedge clk); seen |= ack[2];
    rst[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); seen |= ack[2];
    end
    chk("t5 no ack after reset", {31'd0, seen}, 32'd0);
    txn(2, 0, 32'h20, 32'h0, 4'h0, 4, 32'h0, "t5 read"); rel(2, "t5r");

    // Back-to-back random traffic against a 16-word model.
    foreach (lat_of[d]) begin
      if (d == 2) continue;
      for (int i = 0; i < 16; i++) begin
        mdl[i] = $urandom;
        txn(d, 1, 32'(i) << 2, mdl[i], 4'hF, lat_of[d] + 1, 32'h0, "t6 init"); rel(d, "t6i");
      end
      for (int n = 0; n < 500; n++) begin
        logic [31:0] a, wd, exp;
        logic [3:0] m;
        logic w;
        int idx;
        idx = $urandom_range(0, 15);
        a = {$urandom_range(0, 1048575) & 32'hFFFFF, 6'd0, 4'(idx), 2'($urandom_range(0, 3))};
        w = 1'($urandom_range(0, 1));
        wd = $urandom;
        m = 4'($urandom_range(0, 15));
        exp = w ? 32'h0 : mdl[idx];
        txn(d, w, a, wd, m, lat_of[d] + ((n == 0) ? 1 : 2), exp, "t6 txn");
        if (w)
          for (int b = 0; b < 4; b++)
            if (m[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end
      rel(d, "t6 end");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
